truth_table_sweeper: RTL

Sequencing controller for a 3-input combinational logic gate of the 0xNN truth-table family. It drives the gate's three inputs through all eight combinations and waits a programmable settle time after each. It then samples the gate output and assembles the measured 8-bit truth-table code, which it compares against an expected code. It sits between a test/configuration host and one 3-input gate instance, and is used for characterisation and self-check.

---
 rtl/tt_pkg.sv | 19 +
 rtl/sync2.sv | 24 ++
 rtl/truth_table_sweeper.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the 3-input truth-table sweeper.
package tt_pkg;

    localparam int TT_WIDTH = 8;
    localparam int N_INPUTS = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Row 000 lands in the MSB of the truth-table code.
    function automatic logic [N_INPUTS-1:0] tt_bit_idx(input logic [N_INPUTS-1:0] row);
        return N_INPUTS'(TT_WIDTH - 1) - row;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate through all eight input rows, samples its output after a
// settle time, and assembles and checks the measured truth-table code.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [TT_WIDTH-1:0] expected,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic [TT_WIDTH-1:0] table_out,
    output logic                pass
);

    localparam logic [7:0]          SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] LAST_ROW    = N_INPUTS'(TT_WIDTH - 1);

    state_t              state, state_nxt;
    logic [N_INPUTS-1:0] idx, idx_nxt;
    logic [7:0]          cnt, cnt_nxt;
    logic [TT_WIDTH-1:0] exp_q, exp_nxt;
    logic [TT_WIDTH-1:0] table_q, table_nxt;
    logic                pass_q, pass_nxt;
    logic [N_INPUTS-1:0] dut_in_q, dut_in_nxt;
    logic                dut_out_s;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (dut_out_s)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        exp_nxt    = exp_q;
        table_nxt  = table_q;
        pass_nxt   = pass_q;
        dut_in_nxt = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    exp_nxt   = expected;
                    table_nxt = '0;
                    pass_nxt  = 1'b0;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end

            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    pass_nxt  = 1'b0;
                end else begin
                    dut_in_nxt = idx;
                    if (cnt == SETTLE_LAST) begin
                        state_nxt = SAMPLE;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end

            SAMPLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                    pass_nxt  = 1'b0;
                end else begin
                    table_nxt[tt_bit_idx(idx)] = dut_out_s;
                    if (idx == LAST_ROW) begin
                        state_nxt = DONE;
                        // Registered here so pass is already valid during the done pulse.
                        pass_nxt  = (table_nxt == exp_q);
                    end else begin
                        state_nxt  = DRIVE;
                        idx_nxt    = idx + 1'b1;
                        cnt_nxt    = '0;
                        dut_in_nxt = idx + 1'b1;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            exp_q    <= '0;
            table_q  <= '0;
            pass_q   <= 1'b0;
            dut_in_q <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            exp_q    <= exp_nxt;
            table_q  <= table_nxt;
            pass_q   <= pass_nxt;
            dut_in_q <= dut_in_nxt;
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign table_out = table_q;
    assign pass      = pass_q;

endmodule
